// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter that hands a 4-digit 7-segment display to one of two requesters,
// with a minimum hold time per owner. Optional new-owner blink: define DISP_BLINK_EN.
module seg_display_arbiter #(
  parameter int                HOLD_W    = 24,
  parameter logic [HOLD_W-1:0] HOLD_CYC  = 24'd5000000,
  parameter int                BLINK_BIT = 21
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [15:0] data0,
  input  logic        req1,
  input  logic [15:0] data1,
  output logic [1:0]  gnt,
  output logic [3:0]  dig_a,
  output logic [3:0]  dig_b,
  output logic [3:0]  dig_c,
  output logic [3:0]  dig_d,
  output logic [3:0]  blank,
  output logic        owner_chg
);

  if (BLINK_BIT < 0 || BLINK_BIT >= HOLD_W) begin : g_bad_blink_bit
    $error("seg_display_arbiter: BLINK_BIT must index into hold_cnt");
  end

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t              state_q, state_d;
  logic                last_owner;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [15:0]         dig_q;
  logic                hold_done;

  assign hold_done = (hold_cnt == HOLD_CYC);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = last_owner ? OWN0 : OWN1;
        else if (req0)     state_d = OWN0;
        else if (req1)     state_d = OWN1;
      end
      OWN0: begin
        // Owner keeps the display until the hold time expires, even if it lets go.
        if (hold_done) begin
          if (req1)       state_d = OWN1;
          else if (!req0) state_d = IDLE;
        end
      end
      OWN1: begin
        if (hold_done) begin
          if (req0)       state_d = OWN0;
          else if (!req1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_owner <= 1'b1;
      hold_cnt   <= '0;
      gnt        <= 2'b00;
      dig_q      <= 16'h0000;
      owner_chg  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_chg <= (state_d != state_q);
      if (state_d == IDLE || state_d != state_q)
        hold_cnt <= '0;
      else if (!hold_done)
        hold_cnt <= hold_cnt + {{(HOLD_W-1){1'b0}}, 1'b1};
      case (state_d)
        OWN0: begin
          gnt        <= 2'b01;
          last_owner <= 1'b0;
          // Entering always loads; afterwards track only while the owner still requests.
          if (state_q != OWN0 || req0) dig_q <= data0;
        end
        OWN1: begin
          gnt        <= 2'b10;
          last_owner <= 1'b1;
          if (state_q != OWN1 || req1) dig_q <= data1;
        end
        default: begin
          gnt   <= 2'b00;
          dig_q <= 16'h0000;
        end
      endcase
    end
  end

  assign dig_a = dig_q[15:12];
  assign dig_b = dig_q[11:8];
  assign dig_c = dig_q[7:4];
  assign dig_d = dig_q[3:0];

  always_comb begin
    blank = 4'b1111;
    if (state_q != IDLE) begin
`ifdef DISP_BLINK_EN
      blank = hold_done ? 4'b0000 : {4{hold_cnt[BLINK_BIT]}};
`else
      blank = 4'b0000;
`endif
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Table-driven bench for seg_display_arbiter (HOLD_CYC=8, BLINK_BIT=1) with an expected-output queue.
module tb_seg_display_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [15:0] data0, data1;
  logic [1:0]  gnt;
  logic [3:0]  dig_a, dig_b, dig_c, dig_d, blank;
  logic        owner_chg;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seg_display_arbiter #(.HOLD_W(24), .HOLD_CYC(24'd8), .BLINK_BIT(1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt(gnt), .dig_a(dig_a), .dig_b(dig_b), .dig_c(dig_c), .dig_d(dig_d),
    .blank(blank), .owner_chg(owner_chg)
  );

  // hc: expected hold count after the edge, -1 when no owner
  typedef struct {
    logic        rst, r0, r1;
    logic [15:0] d0, d1;
    logic [1:0]  gnt;
    logic [15:0] dig;
    int          hc;
    logic        chg;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  task automatic add(input logic r, input logic a, input logic b,
                     input logic [15:0] d0, input logic [15:0] d1,
                     input logic [1:0] g, input logic [15:0] dg, input int hc, input logic chg);
    vec_t v;
    v.rst = r; v.r0 = a; v.r1 = b; v.d0 = d0; v.d1 = d1;
    v.gnt = g; v.dig = dg; v.hc = hc; v.chg = chg;
    tbl.push_back(v);
  endtask

  function automatic logic [3:0] exp_blank(input int hc);
    if (hc < 0) return 4'b1111;
`ifdef DISP_BLINK_EN
    if (hc < 8) return {4{hc[1]}};
`endif
    return 4'b0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    vec_t e;
    int   cyc;
    logic got;

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;

    // reset for two cycles
    add(1, 0, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, -1, 0);
    add(1, 0, 0, 16'h0000, 16'h0000, 2'b00, 16'h0000, -1, 0);
    // both request after reset: requester 0 wins
    add(0, 1, 1, 16'h1234, 16'hABCD, 2'b01, 16'h1234, 0, 1);
    for (int h = 1; h <= 3; h++) add(0, 1, 0, 16'h1234, 16'hABCD, 2'b01, 16'h1234, h, 0);
    // owner lets go at hold 3: keeps display, digits frozen, until hold reaches 8
    for (int h = 4; h <= 8; h++) add(0, 0, 0, 16'h5555, 16'hABCD, 2'b01, 16'h1234, h, 0);
    add(0, 0, 0, 16'h5555, 16'hABCD, 2'b00, 16'h0000, -1, 1);
    add(0, 0, 0, 16'h5555, 16'hABCD, 2'b00, 16'h0000, -1, 0);
    // both held high: last owner was 0, so 1 goes first, then alternate every 9 cycles
    add(0, 1, 1, 16'h1234, 16'hABCD, 2'b10, 16'hABCD, 0, 1);
    for (int h = 1; h <= 8; h++) add(0, 1, 1, 16'h1234, 16'hABCD, 2'b10, 16'hABCD, h, 0);
    add(0, 1, 1, 16'h1234, 16'hABCD, 2'b01, 16'h1234, 0, 1);
    for (int h = 1; h <= 8; h++) add(0, 1, 1, 16'h1234, 16'hABCD, 2'b01, 16'h1234, h, 0);
    add(0, 1, 1, 16'h1234, 16'hABCD, 2'b10, 16'hABCD, 0, 1);
    // reset while owner 1 holds: silent abort, then requester 0 wins
    add(1, 1, 1, 16'h1234, 16'hABCD, 2'b00, 16'h0000, -1, 0);
    add(0, 1, 1, 16'h1234, 16'hABCD, 2'b01, 16'h1234, 0, 1);
    // digits follow data0 while req0 high, freeze when it drops
    add(0, 1, 0, 16'h0001, 16'hABCD, 2'b01, 16'h0001, 1, 0);
    add(0, 1, 0, 16'h0002, 16'hABCD, 2'b01, 16'h0002, 2, 0);
    add(0, 0, 0, 16'h0009, 16'hABCD, 2'b01, 16'h0002, 3, 0);
    for (int h = 4; h <= 8; h++) add(0, 1, 0, 16'h0007, 16'hABCD, 2'b01, 16'h0007, h, 0);
    // hold expired, other side idle, owner still wants it: stays
    add(0, 1, 0, 16'h0007, 16'hABCD, 2'b01, 16'h0007, 8, 0);
    // other side shows up after expiry: switch directly
    add(0, 1, 1, 16'h0007, 16'hBEEF, 2'b10, 16'hBEEF, 0, 1);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; req0 = tbl[i].r0; req1 = tbl[i].r1;
      data0 = tbl[i].d0; data1 = tbl[i].d1;
      sb.push_back(tbl[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      check($sformatf("gnt[%0d]", i),   {30'd0, gnt}, {30'd0, e.gnt});
      check($sformatf("dig[%0d]", i),   {16'd0, dig_a, dig_b, dig_c, dig_d}, {16'd0, e.dig});
      check($sformatf("blank[%0d]", i), {28'd0, blank}, {28'd0, exp_blank(e.hc)});
      check($sformatf("chg[%0d]", i),   {31'd0, owner_chg}, {31'd0, e.chg});
      check($sformatf("onehot[%0d]", i), {31'd0, (gnt == 2'b11)}, 32'd0);
    end

    // owner 1 just entered with both requesting: next grant change after exactly 9 edges
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; data0 = 16'h4321;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (owner_chg) got = 1'b1;
    end
    check("switch_seen", {31'd0, got}, 32'd1);
    check("switch_period", cyc, 32'd9);
    check("switch_gnt", {30'd0, gnt}, 32'd1);
    check("switch_dig", {16'd0, dig_a, dig_b, dig_c, dig_d}, 32'h4321);
    @(posedge clk); #1;
    check("chg_one_cycle", {31'd0, owner_chg}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
SEG_DISPLAY_ARBITER -- requirements
Module: seg_display_arbiter

Interface
REQ-001 SHALL have parameter HOLD_W, default 24: width of the hold counter.
REQ-002 SHALL have parameter HOLD_CYC, default 24'd5000000: minimum number of cycles an owner keeps the display.
REQ-003 SHALL have parameter BLINK_BIT, default 21: hold-counter bit that drives the blink phase.
REQ-004 SHALL have port clk  input  1: the single clock; every register is on its rising edge.
REQ-005 SHALL have port rst  input  1: reset; one clock, reset is synchronous and active-high.
REQ-006 SHALL have port req0  input  1: requester 0 wants the display.
REQ-007 SHALL have port data0  input  16: requester 0 value; [15:12] goes to digit A, [3:0] to digit D.
REQ-008 SHALL have port req1  input  1: requester 1 wants the display.
REQ-009 SHALL have port data1  input  16: requester 1 value, same digit mapping as data0.
REQ-010 SHALL have port gnt  output  2: one-hot grant; bit n means requester n owns the display.
REQ-011 SHALL have ports dig_a, dig_b, dig_c, dig_d  output  4 each: nibbles fed to the scanning 7-segment driver.
REQ-012 SHALL have port blank  output  4: per-digit blank, 1 = digit dark; [3] is digit A.
REQ-013 SHALL have port owner_chg  output  1: one-cycle pulse on every grant change.

Function
REQ-014 SHALL implement states IDLE, OWN0 and OWN1, plus a last_owner bit used for round-robin.
REQ-015 In IDLE, with exactly one req high, SHALL move to that requester's OWN state.
REQ-016 In IDLE, with both req high, SHALL grant the requester that is not last_owner.
REQ-017 In IDLE, with no req high, SHALL stay in IDLE.
REQ-018 SHALL clear hold_cnt to 0 on entering an OWN state, then increment it each cycle, saturating at HOLD_CYC.
REQ-019 While hold_cnt < HOLD_CYC, SHALL stay in the current OWN state, even if the owner's req drops.
REQ-020 With hold_cnt == HOLD_CYC and the other req high, SHALL switch directly to the other OWN state, regardless of the owner's req.
REQ-021 With hold_cnt == HOLD_CYC, the other req low and the owner's req low, SHALL go to IDLE.
REQ-022 With hold_cnt == HOLD_CYC, the other req low and the owner's req high, SHALL stay in the current OWN state.
REQ-023 SHALL make gnt, the digit outputs and owner_chg registered; all change on the same edge as the state transition (decision to output: 1 cycle).
REQ-024 On the edge entering OWNn, SHALL load dig_a..dig_d from dataN sampled on that edge.
REQ-025 While in OWNn with reqN high, SHALL reload the digits from dataN every cycle.
REQ-026 While in OWNn with reqN low, SHALL hold the last loaded digits.
REQ-027 SHALL set last_owner to n whenever OWNn is entered.
REQ-028 SHALL drive gnt = 2'b00, blank = 4'b1111 and the digits to 0 in IDLE.
REQ-029 SHALL assert owner_chg for exactly one cycle on each transition IDLE->OWNn, OWNn->OWNm and OWNn->IDLE; it SHALL never assert otherwise.
REQ-030 SHALL never assert both gnt bits at once.
REQ-031 SHALL compare and saturate hold_cnt in HOLD_W bits; HOLD_CYC SHALL be less than 2^HOLD_W, and HOLD_CYC = 0 means arbitration is allowed every cycle.

Reset
REQ-032 With rst high at a clock edge, SHALL force on that edge: state IDLE, gnt 2'b00, digits 0, blank 4'b1111, owner_chg 0, hold_cnt 0, last_owner 1.
REQ-033 Reset asserted mid-ownership SHALL abort the ownership without an owner_chg pulse.
REQ-034 On the first edge after rst falls, SHALL arbitrate normally; with both req high, req0 wins.

Configuration
REQ-035 SHALL use macro DISP_BLINK_EN to compile the new-owner blink feature in or out.
REQ-036 With DISP_BLINK_EN defined, in an OWN state with hold_cnt < HOLD_CYC, SHALL drive blank = {4{hold_cnt[BLINK_BIT]}}.
REQ-037 With DISP_BLINK_EN defined, once hold_cnt == HOLD_CYC, SHALL drive blank = 4'b0000.
REQ-038 Without DISP_BLINK_EN, SHALL drive blank = 4'b0000 in any OWN state, and no blink logic SHALL be present.

Verification (HOLD_CYC=8, BLINK_BIT=1)
REQ-039 SHALL cover: rst=1 for 2 cycles, then req0=req1=1, data0=16'h1234 -> one cycle later gnt=01, dig=1,2,3,4, owner_chg=1 for one cycle.
REQ-040 SHALL cover: owner 0 drops req0 at hold_cnt=3, req1=0 -> gnt stays 01 until hold_cnt=8, then IDLE with blank=1111 and owner_chg pulse.
REQ-041 SHALL cover: req0 and req1 held high -> grant alternates 01/10 every 9 cycles; data1=16'hABCD appears on the digits on the switch edge.
REQ-042 SHALL cover: owner 0 with req0=1, data0 changing 16'h0001 -> 16'h0002 -> digits follow one cycle later; req0 drop -> digits freeze at 0,0,0,2.
REQ-043 SHALL cover: rst pulsed while gnt=10 -> next cycle gnt=00, digits 0, owner_chg=0; then both req high -> gnt=01.
REQ-044 SHALL cover: DISP_BLINK_EN defined -> blank toggles 0000/1111 every 2 cycles during hold, then stays 0000; undefined -> blank=0000 throughout ownership.
